// File: rtl/prog_launcher.sv
// prog_launcher: program launch controller for the CPU core.
// Captures the start/end PCs on a launch request, strobes the start PC into
// the fetch unit, and then enables the core until the halt detector fires. It
// then reports completion and the RUN cycle count, and waits for the host
// to acknowledge.
// Optional watchdog: define PROG_LAUNCHER_TIMEOUT_EN to end a RUN phase that
// lasts TIMEOUT_CYCLES cycles without a halt.
module prog_launcher #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  start_addr,
    input  logic [7:0]  end_addr,
    input  logic        halt,
    input  logic        ack,
    output logic        pc_load,
    output logic [7:0]  pc_load_val,
    output logic [7:0]  pc_end,
    output logic        cpu_run,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // The watchdog limit must fit the 16-bit cycle counter and allow at least one
    // full RUN cycle.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("prog_launcher: TIMEOUT_CYCLES must be in 2..65535");
    end

    state_e      state_q, state_d;
    logic        pc_load_q, pc_load_d;
    logic [7:0]  pc_load_val_q, pc_load_val_d;
    logic [7:0]  pc_end_q, pc_end_d;
    logic        cpu_run_q, cpu_run_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] cycle_count_q, cycle_count_d;
    logic [15:0] count_inc;

`ifdef PROG_LAUNCHER_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic        timeout_q, timeout_d;
`endif

    // The RUN counter saturates instead of wrapping, so very long programs read as 0xFFFF.
    assign count_inc = (cycle_count_q == 16'hFFFF) ? cycle_count_q : cycle_count_q + 16'd1;

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so that every output is registered alongside the state.
    always_comb begin
        state_d       = state_q;
        pc_load_d     = 1'b0;
        pc_load_val_d = pc_load_val_q;
        pc_end_d      = pc_end_q;
        cpu_run_d     = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        cycle_count_d = cycle_count_q;
`ifdef PROG_LAUNCHER_TIMEOUT_EN
        timeout_d     = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = LOAD;
                    pc_load_val_d = start_addr;
                    pc_end_d      = end_addr;
                    cycle_count_d = 16'd0;
`ifdef PROG_LAUNCHER_TIMEOUT_EN
                    timeout_d     = 1'b0;
`endif
                    pc_load_d     = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            LOAD: begin
                // halt is ignored here because it still reflects the stale PC.
                state_d   = RUN;
                cpu_run_d = 1'b1;
                busy_d    = 1'b1;
            end
            RUN: begin
                busy_d        = 1'b1;
                cycle_count_d = count_inc;
                if (halt) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
`ifdef PROG_LAUNCHER_TIMEOUT_EN
                else if (cycle_count_q == TimeoutLast) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
                else begin
                    cpu_run_d = 1'b1;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. The reset is asynchronous, so the outputs
    // clear as soon as reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_load_q     <= 1'b0;
            pc_load_val_q <= 8'h00;
            pc_end_q      <= 8'h00;
            cpu_run_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            pc_load_q     <= pc_load_d;
            pc_load_val_q <= pc_load_val_d;
            pc_end_q      <= pc_end_d;
            cpu_run_q     <= cpu_run_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cycle_count_q <= cycle_count_d;
        end
    end

`ifdef PROG_LAUNCHER_TIMEOUT_EN
    // Register that records whether the last completion came from the watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign pc_load     = pc_load_q;
    assign pc_load_val = pc_load_val_q;
    assign pc_end      = pc_end_q;
    assign cpu_run     = cpu_run_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_count = cycle_count_q;

endmodule
